// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encodings and width helpers.
// Imported by the arbiter top and its priority picker.
package round_robin_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_GRANTED    = 2'd1,
        ARB_TURNAROUND = 2'd2
    } arb_state_t;

    // Binary index width for n requesters; never narrower than one bit.
    function automatic int index_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width needed to hold a counter that saturates at value max_val.
    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/round_robin_arbiter_rr_priority_pick.sv
// Combinational rotating-priority picker: first set request after last_owner,
// wrapping modulo INPUTS, found by masking a doubled request vector.
module rr_priority_pick
    import round_robin_arbiter_pkg::*;
#(
    parameter int INPUTS      = 4,
    parameter int INDEX_WIDTH = index_width(INPUTS)
) (
    input  logic [INPUTS-1:0]      request,
    input  logic [INDEX_WIDTH-1:0] last_owner,
    output logic [INPUTS-1:0]      winner,
    output logic [INDEX_WIDTH-1:0] winner_index,
    output logic                   found
);

    localparam int DW = 2 * INPUTS;

    logic [DW-1:0] doubled;
    logic [DW-1:0] mask;
    logic [DW-1:0] masked;

    // Positions last_owner+1 .. last_owner+INPUTS of the doubled vector visit
    // every requester exactly once, in rotation order.
    assign doubled = {request, request};
    assign mask    = {DW{1'b1}} << (int'(last_owner) + 1);
    assign masked  = doubled & mask;

    always_comb begin
        winner       = '0;
        winner_index = '0;
        found        = 1'b0;
        for (int p = 0; p < DW; p++) begin
            if (masked[p] && !found) begin
                found        = 1'b1;
                winner_index = INDEX_WIDTH'(p % INPUTS);
                winner       = INPUTS'(1) << (p % INPUTS);
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter with bus turnaround gap and optional hold limit.
// grant drives the one-hot select of the shared output mux.
//
//   state          | meaning
//   ARB_IDLE       | no owner; arbitrate among current requests
//   ARB_GRANTED    | one owner holds the bus; count hold cycles
//   ARB_TURNAROUND | one-cycle bus release gap after an owner leaves
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int INPUTS      = 4,
    parameter int HOLD_LIMIT  = 0,
    parameter int INDEX_WIDTH = index_width(INPUTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INPUTS-1:0]      request,
    input  logic [INPUTS-1:0]      lock,
    output logic [INPUTS-1:0]      grant,
    output logic                   grantValid,
    output logic [INDEX_WIDTH-1:0] grantIndex,
    output logic                   preempted
);

    localparam int HOLD_WIDTH = count_width(HOLD_LIMIT);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX  = HOLD_WIDTH'(HOLD_LIMIT);
    localparam logic [HOLD_WIDTH-1:0] HOLD_TRIP =
        HOLD_WIDTH'((HOLD_LIMIT == 0) ? 0 : HOLD_LIMIT - 1);

    arb_state_t             state;
    logic [INDEX_WIDTH-1:0] last_owner;
    logic [HOLD_WIDTH-1:0]  hold_count;

    logic [INPUTS-1:0]      pick_winner;
    logic [INDEX_WIDTH-1:0] pick_index;
    logic                   pick_found;

    logic owner_request;
    logic owner_locked;
    logic others_waiting;
    logic hold_hit;

    rr_priority_pick #(
        .INPUTS      (INPUTS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pick (
        .request      (request),
        .last_owner   (last_owner),
        .winner       (pick_winner),
        .winner_index (pick_index),
        .found        (pick_found)
    );

    assign owner_request  = |(request & grant);
    assign owner_locked   = |(lock & grant);
    assign others_waiting = |(request & ~grant);
    // Compare with >= so that an owner whose lock kept it past the limit
    // (counter saturated) is preempted as soon as the lock drops.
    assign hold_hit       = (HOLD_LIMIT != 0) && (hold_count >= HOLD_TRIP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            grantValid <= 1'b0;
            grantIndex <= INDEX_WIDTH'(INPUTS - 1);
            last_owner <= INDEX_WIDTH'(INPUTS - 1);
            hold_count <= '0;
            preempted  <= 1'b0;
        end else begin
            preempted <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    hold_count <= '0;
                    if (pick_found) begin
                        grant      <= pick_winner;
                        grantValid <= 1'b1;
                        grantIndex <= pick_index;
                        state      <= ARB_GRANTED;
                    end
                end
                ARB_GRANTED: begin
                    if (hold_count != HOLD_MAX) begin
                        hold_count <= hold_count + 1'b1;
                    end
                    if (!owner_request) begin
                        grant      <= '0;
                        grantValid <= 1'b0;
                        last_owner <= grantIndex;
                        state      <= ARB_TURNAROUND;
                    end else if (hold_hit && !owner_locked && others_waiting) begin
                        grant      <= '0;
                        grantValid <= 1'b0;
                        preempted  <= 1'b1;
                        last_owner <= grantIndex;
                        state      <= ARB_TURNAROUND;
                    end
                end
                ARB_TURNAROUND: begin
                    hold_count <= '0;
                    state      <= ARB_IDLE;
                end
                default: begin
                    grant      <= '0;
                    grantValid <= 1'b0;
                    hold_count <= '0;
                    state      <= ARB_IDLE;
                end
            endcase
        end
    end

    grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    valid_match:  assert property (@(posedge clk) disable iff (!rst_n) grantValid == |grant);

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Testbench for round_robin_arbiter: an unlimited-hold and a HOLD_LIMIT=4 instance
// share stimulus and are checked every cycle against a behavioural model.
module tb_round_robin_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] request;
    logic [N-1:0] lock;

    logic [N-1:0] grant_a, grant_b;
    logic         valid_a, valid_b;
    logic [1:0]   index_a, index_b;
    logic         pre_a, pre_b;

    int n_checks = 0;
    int n_fail   = 0;

    int m_owner[2];
    int m_wait[2];
    int m_last[2];
    int m_held[2];
    int m_index[2];
    bit m_pre[2];
    int hl[2] = '{0, 4};

    always #5 clk = ~clk;

    round_robin_arbiter #(.INPUTS(N), .HOLD_LIMIT(0)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .request    (request),
        .lock       (lock),
        .grant      (grant_a),
        .grantValid (valid_a),
        .grantIndex (index_a),
        .preempted  (pre_a)
    );

    round_robin_arbiter #(.INPUTS(N), .HOLD_LIMIT(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .request    (request),
        .lock       (lock),
        .grant      (grant_b),
        .grantValid (valid_b),
        .grantIndex (index_b),
        .preempted  (pre_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_wait[i]  = 0;
            m_last[i]  = N - 1;
            m_index[i] = N - 1;
            m_held[i]  = 0;
            m_pre[i]   = 1'b0;
        end
    endtask

    // One rising edge of the reference: owner keeps the bus until it drops its
    // request or outstays the hold limit; a released bus idles one cycle, then
    // the next requester after the previous owner (cyclically) wins.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_pre[i] = 1'b0;
            if (m_owner[i] >= 0) begin
                logic [N-1:0] others;
                m_held[i]++;
                others = request & ~(N'(1) << m_owner[i]);
                if (!request[m_owner[i]]) begin
                    m_last[i]  = m_owner[i];
                    m_owner[i] = -1;
                    m_wait[i]  = 1;
                end else if (hl[i] != 0 && m_held[i] >= hl[i] && !lock[m_owner[i]] && others != 0) begin
                    m_pre[i]   = 1'b1;
                    m_last[i]  = m_owner[i];
                    m_owner[i] = -1;
                    m_wait[i]  = 1;
                end
            end else if (m_wait[i] > 0) begin
                m_wait[i]--;
            end else if (request != 0) begin
                bit got = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int idx = (m_last[i] + k) % N;
                    if (!got && request[idx]) begin
                        got        = 1'b1;
                        m_owner[i] = idx;
                        m_index[i] = idx;
                        m_held[i]  = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_grant(input int i);
        return (m_owner[i] >= 0) ? (N'(1) << m_owner[i]) : '0;
    endfunction

    task automatic compare_all();
        check_val("a_grant", grant_a, exp_grant(0));
        check_val("a_valid", valid_a, m_owner[0] >= 0);
        check_val("a_index", index_a, m_index[0]);
        check_val("a_preempted", pre_a, m_pre[0]);
        check_val("b_grant", grant_b, exp_grant(1));
        check_val("b_valid", valid_b, m_owner[1] >= 0);
        check_val("b_index", index_b, m_index[1]);
        check_val("b_preempted", pre_b, m_pre[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        compare_all();
    endtask

    task automatic settle();
        request = '0;
        lock    = '0;
        repeat (4) step();
    endtask

    initial begin
        int cnt;
        int pulses;
        int t;
        logic [N-1:0] order[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [N-1:0] bitv;

        rst_n   = 1'b0;
        request = '0;
        lock    = '0;
        model_reset();
        repeat (2) step();
        check_val("reset_grant", grant_b, 4'b0000);
        check_val("reset_index", index_b, 3);
        rst_n = 1'b1;

        // Basic latency and turnaround gap
        request = 4'b1010;
        step();
        check_val("t1_first_grant", grant_b, 4'b0010);
        check_val("t1_first_index", index_b, 1);
        request = 4'b1000;
        step();
        check_val("t1_gap0", grant_b, 4'b0000);
        step();
        check_val("t1_gap1", grant_b, 4'b0000);
        step();
        check_val("t1_next_grant", grant_b, 4'b1000);
        check_val("t1_next_index", index_b, 3);
        settle();

        // Full rotation, each owner releasing after two grant cycles
        request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            while (grant_b == 0 && t < 8) begin
                step();
                t++;
            end
            check_val("t2_order", grant_b, order[k]);
            step();
            bitv    = grant_b;
            request = request & ~bitv;
            step();
            check_val("t2_gap", grant_b, 4'b0000);
            request = request | bitv;
        end
        settle();

        // Hold-limit preemption
        request = 4'b0001;
        step();
        request = 4'b0101;
        cnt     = (grant_b == 4'b0001) ? 1 : 0;
        pulses  = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (grant_b == 4'b0001) cnt++;
            if (pre_b) pulses++;
        end
        check_val("t3_hold_len", cnt, 4);
        check_val("t3_preempt_cnt", pulses, 1);
        check_val("t3_new_owner", grant_b, 4'b0100);
        settle();

        // Lock suppresses preemption until released
        lock    = 4'b0001;
        request = 4'b0001;
        step();
        request = 4'b0101;
        cnt     = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (grant_b == 4'b0001 && !pre_b) cnt++;
        end
        check_val("t4_locked_cycles", cnt, 10);
        lock = 4'b0000;
        step();
        check_val("t4_preempt_after_unlock", pre_b, 1'b1);
        settle();

        // Single requester never preempted
        request = 4'b1000;
        cnt     = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (grant_b == 4'b1000 && !pre_b) cnt++;
        end
        check_val("t5_solo_cycles", cnt, 20);
        settle();

        // Asynchronous reset mid-ownership
        request = 4'b0100;
        step();
        check_val("t6_pre_reset_grant", grant_b, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("t6_async_grant_a", grant_a, 4'b0000);
        check_val("t6_async_grant_b", grant_b, 4'b0000);
        check_val("t6_async_valid_b", valid_b, 1'b0);
        request = 4'b1111;
        step();
        rst_n = 1'b1;
        step();
        check_val("t6_restart_grant", grant_b, 4'b0001);
        settle();

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < N; j++) begin
                if (!request[j] && $urandom_range(0, 3) == 0) request[j] = 1'b1;
                else if (request[j] && $urandom_range(0, 7) == 0) request[j] = 1'b0;
                lock[j] = ($urandom_range(0, 4) == 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
